// File: rtl/pwm_pkg.sv
// Shared types and helpers for the multi-channel PWM generator.
// Contents:
//   PWM_CNT_W_DEF / PWM_PRESC_W_DEF - default counter and prescaler widths
//   pwm_mode_e                      - edge- or center-aligned counting
//   pwm_cfg_t                       - channel configuration record at default widths
//   PWM_DIR_UP / PWM_DIR_DOWN       - center-mode count direction encoding
//   pwm_ch_w()                      - width of a channel index, at least one bit
package pwm_pkg;

    localparam int PWM_CNT_W_DEF   = 16;
    localparam int PWM_PRESC_W_DEF = 8;

    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_e;

    typedef struct packed {
        logic [PWM_CNT_W_DEF-1:0]   period;
        logic [PWM_CNT_W_DEF-1:0]   duty;
        logic [PWM_PRESC_W_DEF-1:0] presc;
        pwm_mode_e                  mode;
        logic                       pol;
    } pwm_cfg_t;

    localparam logic PWM_DIR_UP   = 1'b0;
    localparam logic PWM_DIR_DOWN = 1'b1;

    // A single-channel build still needs a one-bit channel select port.
    function automatic int pwm_ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pwm_core.sv
// One PWM channel: shadow and active configuration, prescaler, up or
// up/down counter, compare stage and registered pad outputs.
// Ports:
//   i_clock, i_rst            - block clock, asynchronous active-high reset
//   i_en                      - channel enable
//   i_we                      - shadow write strobe (already decoded for this channel)
//   i_period/i_duty/i_presc   - shadow values; i_presc is divisor minus one
//   i_mode, i_pol             - 0 edge / 1 center, 1 inverts the output
//   o_pwm, o_oe, o_done       - registered output, output enable, update-event pulse
module pwm_core
    import pwm_pkg::*;
#(
    parameter int CNT_W   = PWM_CNT_W_DEF,
    parameter int PRESC_W = PWM_PRESC_W_DEF
) (
    input  logic               i_clock,
    input  logic               i_rst,
    input  logic               i_en,
    input  logic               i_we,
    input  logic [CNT_W-1:0]   i_period,
    input  logic [CNT_W-1:0]   i_duty,
    input  logic [PRESC_W-1:0] i_presc,
    input  logic               i_mode,
    input  logic               i_pol,
    output logic               o_pwm,
    output logic               o_oe,
    output logic               o_done
);

    typedef struct packed {
        logic [CNT_W-1:0]   period;
        logic [CNT_W-1:0]   duty;
        logic [PRESC_W-1:0] presc;
        pwm_mode_e          mode;
        logic               pol;
    } ch_cfg_t;

    ch_cfg_t            r_shd;
    ch_cfg_t            r_act;
    ch_cfg_t            w_cfg_in;
    logic [PRESC_W-1:0] r_presc_cnt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_dir;
    logic               w_dir_nxt;
    logic               w_tick;
    logic               w_event;
    logic               r_pwm;
    logic               r_oe;
    logic               r_done;

    // Pack the incoming configuration fields into one record.
    always_comb begin
        w_cfg_in.period = i_period;
        w_cfg_in.duty   = i_duty;
        w_cfg_in.presc  = i_presc;
        w_cfg_in.mode   = pwm_mode_e'(i_mode);
        w_cfg_in.pol    = i_pol;
    end

    // Next counter value, direction and update event for the current tick.
    always_comb begin
        w_tick    = (r_presc_cnt >= r_act.presc);
        w_cnt_nxt = r_cnt;
        w_dir_nxt = r_dir;
        w_event   = 1'b0;
        case (r_act.mode)
            PWM_EDGE: begin
                if (r_cnt >= r_act.period) begin
                    w_cnt_nxt = {CNT_W{1'b0}};
                    w_event   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            PWM_CENTER: begin
                if (r_act.period == {CNT_W{1'b0}}) begin
                    w_event = 1'b1;
                end else if (r_dir == PWM_DIR_UP) begin
                    if (r_cnt >= r_act.period) begin
                        // Peak: turn around; with period 1 the turn lands on the bottom.
                        w_cnt_nxt = r_act.period - CNT_W'(1);
                        w_dir_nxt = PWM_DIR_DOWN;
                        w_event   = (r_act.period == CNT_W'(1));
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end else begin
                    if (r_cnt <= CNT_W'(1)) begin
                        w_event = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
            end
            default: begin
                w_event = 1'b1;
            end
        endcase
        // Every period restarts from the bottom counting up.
        if (w_event) begin
            w_cnt_nxt = {CNT_W{1'b0}};
            w_dir_nxt = PWM_DIR_UP;
        end else begin
            w_cnt_nxt = w_cnt_nxt;
        end
    end

    // Shadow register: captures host writes at any time.
    always_ff @(posedge i_clock or posedge i_rst) begin
        if (i_rst) begin
            r_shd <= '0;
        end else if (i_we) begin
            r_shd <= w_cfg_in;
        end
    end

    // Active configuration, prescaler, counter and registered outputs.
    always_ff @(posedge i_clock or posedge i_rst) begin
        if (i_rst) begin
            r_act       <= '0;
            r_presc_cnt <= {PRESC_W{1'b0}};
            r_cnt       <= {CNT_W{1'b0}};
            r_dir       <= PWM_DIR_UP;
            r_pwm       <= 1'b0;
            r_oe        <= 1'b0;
            r_done      <= 1'b0;
        end else if (!i_en) begin
            // Idle: track the shadow so a restart uses the latest settings.
            r_act       <= r_shd;
            r_presc_cnt <= {PRESC_W{1'b0}};
            r_cnt       <= {CNT_W{1'b0}};
            r_dir       <= PWM_DIR_UP;
            r_pwm       <= r_shd.pol;
            r_oe        <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_oe   <= 1'b1;
            r_done <= w_tick & w_event;
            if (w_tick) begin
                r_presc_cnt <= {PRESC_W{1'b0}};
                r_pwm       <= (r_cnt < r_act.duty) ^ r_act.pol;
                r_cnt       <= w_cnt_nxt;
                r_dir       <= w_dir_nxt;
                if (w_event) begin
                    r_act <= r_shd;
                end
            end else begin
                r_presc_cnt <= r_presc_cnt + PRESC_W'(1);
            end
        end
    end

    assign o_pwm  = r_pwm;
    assign o_oe   = r_oe;
    assign o_done = r_done;

endmodule

// File: rtl/pwm_multi_channel.sv
// N-channel PWM generator top: decodes the shadow write strobe to the
// addressed channel and instantiates one pwm_core per channel.
// Ports:
//   clock, rst_i        - block clock, asynchronous active-high reset
//   en_i[NUM_CH]        - per-channel enable
//   cfg_we_i, cfg_ch_i  - shadow write strobe and target channel (out-of-range ignored)
//   cfg_period_i, cfg_duty_i, cfg_presc_i, cfg_mode_i, cfg_pol_i - shadow values
//   pwm_o, oe_o         - registered pad outputs and output enables
//   period_done_o       - one-cycle pulse per channel update event
module pwm_multi_channel
    import pwm_pkg::*;
#(
    parameter  int NUM_CH  = 4,
    parameter  int CNT_W   = PWM_CNT_W_DEF,
    parameter  int PRESC_W = PWM_PRESC_W_DEF,
    localparam int CH_W    = pwm_ch_w(NUM_CH)
) (
    input  logic               clock,
    input  logic               rst_i,
    input  logic [NUM_CH-1:0]  en_i,
    input  logic               cfg_we_i,
    input  logic [CH_W-1:0]    cfg_ch_i,
    input  logic [CNT_W-1:0]   cfg_period_i,
    input  logic [CNT_W-1:0]   cfg_duty_i,
    input  logic [PRESC_W-1:0] cfg_presc_i,
    input  logic               cfg_mode_i,
    input  logic               cfg_pol_i,
    output logic [NUM_CH-1:0]  pwm_o,
    output logic [NUM_CH-1:0]  oe_o,
    output logic [NUM_CH-1:0]  period_done_o
);

    logic [NUM_CH-1:0] w_we;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign w_we[g] = cfg_we_i && (cfg_ch_i == CH_W'(g));

        pwm_core #(
            .CNT_W   (CNT_W),
            .PRESC_W (PRESC_W)
        ) u_core (
            .i_clock  (clock),
            .i_rst    (rst_i),
            .i_en     (en_i[g]),
            .i_we     (w_we[g]),
            .i_period (cfg_period_i),
            .i_duty   (cfg_duty_i),
            .i_presc  (cfg_presc_i),
            .i_mode   (cfg_mode_i),
            .i_pol    (cfg_pol_i),
            .o_pwm    (pwm_o[g]),
            .o_oe     (oe_o[g]),
            .o_done   (period_done_o[g])
        );
    end

endmodule

// File: tb/tb_pwm_multi_channel.sv
module tb_pwm_multi_channel;

    localparam int NUM_CH  = 3;
    localparam int CNT_W   = 8;
    localparam int PRESC_W = 4;

    logic               clock;
    logic               rst;
    logic [NUM_CH-1:0]  en;
    logic               cfg_we;
    logic [1:0]         cfg_ch;
    logic [CNT_W-1:0]   cfg_period;
    logic [CNT_W-1:0]   cfg_duty;
    logic [PRESC_W-1:0] cfg_presc;
    logic               cfg_mode;
    logic               cfg_pol;
    logic [NUM_CH-1:0]  pwm_o;
    logic [NUM_CH-1:0]  oe_o;
    logic [NUM_CH-1:0]  period_done_o;

    pwm_multi_channel #(
        .NUM_CH  (NUM_CH),
        .CNT_W   (CNT_W),
        .PRESC_W (PRESC_W)
    ) dut (
        .clock         (clock),
        .rst_i         (rst),
        .en_i          (en),
        .cfg_we_i      (cfg_we),
        .cfg_ch_i      (cfg_ch),
        .cfg_period_i  (cfg_period),
        .cfg_duty_i    (cfg_duty),
        .cfg_presc_i   (cfg_presc),
        .cfg_mode_i    (cfg_mode),
        .cfg_pol_i     (cfg_pol),
        .pwm_o         (pwm_o),
        .oe_o          (oe_o),
        .period_done_o (period_done_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a channel is described by its position within the
    // current period (ticks since the period began) rather than a counter.
    int s_per[NUM_CH], s_duty[NUM_CH], s_presc[NUM_CH];
    bit s_mode[NUM_CH], s_pol[NUM_CH];
    int a_per[NUM_CH], a_duty[NUM_CH], a_presc[NUM_CH];
    bit a_mode[NUM_CH], a_pol[NUM_CH];
    int since_tick[NUM_CH];
    int pos[NUM_CH];
    logic [NUM_CH-1:0] exp_pwm, exp_oe, exp_done;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Counter value seen at a given position in the period.
    function automatic int cnt_at(input int p, input int per, input bit mode);
        if (!mode) return p;
        return (p <= per) ? p : 2 * per - p;
    endfunction

    // Period length in ticks.
    function automatic int period_ticks(input int per, input bit mode);
        if (!mode) return per + 1;
        return (per == 0) ? 1 : 2 * per;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            s_per[c] = 0; s_duty[c] = 0; s_presc[c] = 0; s_mode[c] = 0; s_pol[c] = 0;
            a_per[c] = 0; a_duty[c] = 0; a_presc[c] = 0; a_mode[c] = 0; a_pol[c] = 0;
            since_tick[c] = 0; pos[c] = 0;
        end
        exp_pwm = '0; exp_oe = '0; exp_done = '0;
    endtask

    task automatic load_active(input int c);
        a_per[c] = s_per[c]; a_duty[c] = s_duty[c]; a_presc[c] = s_presc[c];
        a_mode[c] = s_mode[c]; a_pol[c] = s_pol[c];
    endtask

    // Advance the model by one clock using the inputs presented at that edge.
    task automatic model_step();
        for (int c = 0; c < NUM_CH; c++) begin
            if (!en[c]) begin
                load_active(c);
                since_tick[c] = 0;
                pos[c]        = 0;
                exp_pwm[c]    = a_pol[c];
                exp_oe[c]     = 1'b0;
                exp_done[c]   = 1'b0;
            end else begin
                exp_oe[c]   = 1'b1;
                exp_done[c] = 1'b0;
                if (since_tick[c] == a_presc[c]) begin
                    since_tick[c] = 0;
                    exp_pwm[c] = (cnt_at(pos[c], a_per[c], a_mode[c]) < a_duty[c]) ^ a_pol[c];
                    if (pos[c] == period_ticks(a_per[c], a_mode[c]) - 1) begin
                        exp_done[c] = 1'b1;
                        load_active(c);
                        pos[c] = 0;
                    end else begin
                        pos[c]++;
                    end
                end else begin
                    since_tick[c]++;
                end
            end
        end
        if (cfg_we && int'(cfg_ch) < NUM_CH) begin
            s_per[cfg_ch]   = int'(cfg_period);
            s_duty[cfg_ch]  = int'(cfg_duty);
            s_presc[cfg_ch] = int'(cfg_presc);
            s_mode[cfg_ch]  = cfg_mode;
            s_pol[cfg_ch]   = cfg_pol;
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        model_step();
        @(negedge clock);
        check("pwm_o", 32'(pwm_o), 32'(exp_pwm));
        check("oe_o", 32'(oe_o), 32'(exp_oe));
        check("period_done_o", 32'(period_done_o), 32'(exp_done));
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic wr(input int ch, input int per, input int duty, input int presc,
                      input int mode, input int pol);
        cfg_ch     = 2'(ch);
        cfg_period = CNT_W'(per);
        cfg_duty   = CNT_W'(duty);
        cfg_presc  = PRESC_W'(presc);
        cfg_mode   = 1'(mode);
        cfg_pol    = 1'(pol);
        cfg_we     = 1'b1;
        cyc();
        cfg_we     = 1'b0;
    endtask

    task automatic count_run(input int ch, input int n, output int hi, output int dn);
        hi = 0;
        dn = 0;
        repeat (n) begin
            cyc();
            hi += int'(pwm_o[ch]);
            dn += int'(period_done_o[ch]);
        end
    endtask

    task automatic wait_done(input int ch);
        bit seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            cyc();
            if (period_done_o[ch]) seen = 1'b1;
        end
        if (!seen) check("wait_done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int hi, dn, idx;
        rst = 1'b1; en = '0; cfg_we = 1'b0; cfg_ch = 2'd0;
        cfg_period = '0; cfg_duty = '0; cfg_presc = '0; cfg_mode = 1'b0; cfg_pol = 1'b0;
        model_reset();
        repeat (2) @(negedge clock);
        check("reset_pwm", 32'(pwm_o), 32'd0);
        check("reset_oe", 32'(oe_o), 32'd0);
        check("reset_done", 32'(period_done_o), 32'd0);
        rst = 1'b0;
        run(2);

        // Edge mode: period 9, duty 3 -> 3 high / 7 low, event every 10 cycles.
        wr(0, 9, 3, 0, 0, 0);
        run(2);
        en[0] = 1'b1;
        run(5);
        count_run(0, 20, hi, dn);
        check("edge_high_cycles", 32'(hi), 32'd6);
        check("edge_done_pulses", 32'(dn), 32'd2);

        // Center mode on ch2 alongside ch0: period 4, duty 2, presc 1 -> 16-cycle period.
        wr(2, 4, 2, 1, 1, 0);
        run(2);
        en[2] = 1'b1;
        run(20);
        count_run(2, 32, hi, dn);
        check("center_high_cycles", 32'(hi), 32'd12);
        check("center_done_pulses", 32'(dn), 32'd2);

        // Mid-period shadow write leaves the running period alone.
        wait_done(0);
        run(4);
        wr(0, 9, 7, 0, 0, 0);
        count_run(0, 5, hi, dn);
        check("midwrite_tail_high", 32'(hi), 32'd0);
        check("midwrite_tail_done", 32'(dn), 32'd1);
        count_run(0, 10, hi, dn);
        check("midwrite_next_high", 32'(hi), 32'd7);
        // Write landing on the update event applies one period later.
        run(9);
        wr(0, 9, 1, 0, 0, 0);
        check("evtwrite_is_event", 32'(period_done_o[0]), 32'd1);
        count_run(0, 10, hi, dn);
        check("evtwrite_old_duty", 32'(hi), 32'd7);
        count_run(0, 10, hi, dn);
        check("evtwrite_new_duty", 32'(hi), 32'd1);

        // Out-of-range channel write is ignored.
        wr(3, 1, 1, 0, 0, 1);
        run(12);
        count_run(0, 10, hi, dn);
        check("bad_ch_ignored", 32'(hi), 32'd1);

        // Boundaries on ch1, period 5.
        wr(1, 5, 0, 0, 0, 0);
        run(2);
        en[1] = 1'b1;
        run(14);
        count_run(1, 12, hi, dn);
        check("duty0_low", 32'(hi), 32'd0);
        wr(1, 5, 6, 0, 0, 0);
        run(14);
        count_run(1, 12, hi, dn);
        check("duty_over_high", 32'(hi), 32'd12);
        wr(1, 5, 6, 0, 0, 1);
        run(14);
        count_run(1, 12, hi, dn);
        check("pol_duty_over_low", 32'(hi), 32'd0);
        wr(1, 5, 0, 0, 0, 1);
        run(14);
        count_run(1, 12, hi, dn);
        check("pol_duty0_high", 32'(hi), 32'd12);
        en[1] = 1'b0;
        cyc();
        check("disabled_pwm_is_pol", 32'(pwm_o[1]), 32'd1);
        check("disabled_oe_low", 32'(oe_o[1]), 32'd0);

        // Disable ch0 mid-period, reconfigure, re-enable from cnt 0.
        run(3);
        en[0] = 1'b0;
        cyc();
        check("abort_oe", 32'(oe_o[0]), 32'd0);
        check("abort_pwm", 32'(pwm_o[0]), 32'd0);
        wr(0, 3, 2, 0, 0, 0);
        run(2);
        en[0] = 1'b1;
        cyc();
        check("restart_oe", 32'(oe_o[0]), 32'd1);
        check("restart_first_high", 32'(pwm_o[0]), 32'd1);
        count_run(0, 8, hi, dn);
        check("restart_high", 32'(hi), 32'd4);
        check("restart_done", 32'(dn), 32'd2);

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                cfg_ch     = 2'($urandom_range(0, 3));
                cfg_period = CNT_W'($urandom_range(0, 12));
                cfg_duty   = CNT_W'($urandom_range(0, 14));
                cfg_presc  = PRESC_W'($urandom_range(0, 3));
                cfg_mode   = 1'($urandom_range(0, 1));
                cfg_pol    = 1'($urandom_range(0, 1));
                cfg_we     = 1'b1;
            end else begin
                cfg_we = 1'b0;
            end
            if ($urandom_range(0, 19) == 0) begin
                idx = int'($urandom_range(0, NUM_CH - 1));
                en[idx] = ~en[idx];
            end
            cyc();
        end
        cfg_we = 1'b0;
        en = '1;
        run(25);

        // Asynchronous reset mid-period clears every output at once.
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_pwm", 32'(pwm_o), 32'd0);
        check("async_rst_oe", 32'(oe_o), 32'd0);
        check("async_rst_done", 32'(period_done_o), 32'd0);
        model_reset();
        repeat (2) @(negedge clock);
        rst = 1'b0;
        run(30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
